lii_req_arbiter: RTL and testbench

LII_REQ_ARBITER -- requirements
Module: lii_req_arbiter

---
 rtl/lii_req_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_lii_req_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_req_arbiter.sv
// lii_req_arbiter
//   Round-robin, packet-atomic arbiter that merges NUM_PORTS LII request streams onto one shared
//   request stream, and routes the shared response stream back to requesters by destination ID.
//
// Ports
//   clk, rst                   : clock (rising edge) and asynchronous active-high reset
//   s_req_*   (NUM_PORTS slices): per-requester request streams in; s_req_tready out
//   m_req_*                     : shared request stream out; m_req_tready in
//   m_resp_*                    : shared response stream in; m_resp_tready out
//   s_resp_*  (NUM_PORTS slices): per-requester response streams out; s_resp_tready in
//   pkt_cnt   (NUM_PORTS x 16)  : per-port count of granted request packets (wrapping)
//   err_unroutable              : sticky, set when a response with an unknown dst is dropped

module lii_req_arbiter #(
  parameter int unsigned                  LII_DW    = 128,
  parameter int unsigned                  NUM_PORTS = 4,
  parameter logic [8*NUM_PORTS-1:0]       PORT_IDS  = {8'h03, 8'h02, 8'h01, 8'h00}
) (
  input  logic                            clk,
  input  logic                            rst,
  // Per-requester request streams
  input  logic [NUM_PORTS*LII_DW-1:0]     s_req_tdata,
  input  logic [NUM_PORTS*LII_DW/8-1:0]   s_req_tkeep,
  input  logic [NUM_PORTS*LII_DW/8-1:0]   s_req_tstrb,
  input  logic [NUM_PORTS-1:0]            s_req_tlast,
  input  logic [NUM_PORTS*8-1:0]          s_req_src,
  input  logic [NUM_PORTS*8-1:0]          s_req_dst,
  input  logic [NUM_PORTS-1:0]            s_req_tvalid,
  output logic [NUM_PORTS-1:0]            s_req_tready,
  // Shared request stream
  output logic [LII_DW-1:0]               m_req_tdata,
  output logic [LII_DW/8-1:0]             m_req_tkeep,
  output logic [LII_DW/8-1:0]             m_req_tstrb,
  output logic                            m_req_tlast,
  output logic [7:0]                      m_req_src,
  output logic [7:0]                      m_req_dst,
  output logic                            m_req_tvalid,
  input  logic                            m_req_tready,
  // Shared response stream
  input  logic [LII_DW-1:0]               m_resp_tdata,
  input  logic [LII_DW/8-1:0]             m_resp_tkeep,
  input  logic [LII_DW/8-1:0]             m_resp_tstrb,
  input  logic                            m_resp_tlast,
  input  logic [7:0]                      m_resp_src,
  input  logic [7:0]                      m_resp_dst,
  input  logic                            m_resp_tvalid,
  output logic                            m_resp_tready,
  // Per-requester response streams
  output logic [NUM_PORTS*LII_DW-1:0]     s_resp_tdata,
  output logic [NUM_PORTS*LII_DW/8-1:0]   s_resp_tkeep,
  output logic [NUM_PORTS*LII_DW/8-1:0]   s_resp_tstrb,
  output logic [NUM_PORTS-1:0]            s_resp_tlast,
  output logic [NUM_PORTS*8-1:0]          s_resp_src,
  output logic [NUM_PORTS*8-1:0]          s_resp_dst,
  output logic [NUM_PORTS-1:0]            s_resp_tvalid,
  input  logic [NUM_PORTS-1:0]            s_resp_tready,
  // Status
  output logic [NUM_PORTS*16-1:0]         pkt_cnt,
  output logic                            err_unroutable
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned KW = LII_DW / 8;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_grant, w_grant_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [15:0]     r_pkt_cnt [NUM_PORTS];
  logic            r_err;

  logic [LII_DW-1:0] w_req_data [NUM_PORTS];
  logic [KW-1:0]     w_req_keep [NUM_PORTS];
  logic [KW-1:0]     w_req_strb [NUM_PORTS];
  logic [7:0]        w_req_src  [NUM_PORTS];
  logic [7:0]        w_req_dst  [NUM_PORTS];

  logic            w_arb_found;
  logic [PW-1:0]   w_arb_idx;
  int unsigned     w_arb_pos;
  logic            w_last_fire;
  logic            w_resp_hit;
  logic [PW-1:0]   w_resp_idx;

  // Split the flattened request buses into per-port views.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_req_data[gi]        = s_req_tdata[gi*LII_DW +: LII_DW];
    assign w_req_keep[gi]        = s_req_tkeep[gi*KW +: KW];
    assign w_req_strb[gi]        = s_req_tstrb[gi*KW +: KW];
    assign w_req_src[gi]         = s_req_src[gi*8 +: 8];
    assign w_req_dst[gi]         = s_req_dst[gi*8 +: 8];
    assign pkt_cnt[gi*16 +: 16]  = r_pkt_cnt[gi];
  end

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = r_rr_ptr;
    w_arb_pos   = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      w_arb_pos = (32'(r_rr_ptr) + k) % NUM_PORTS;
      if (!w_arb_found && s_req_tvalid[PW'(w_arb_pos)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = PW'(w_arb_pos);
      end
    end
  end

  // Request FSM: next state and request-path outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_nxt     = r_rr_ptr;
    w_last_fire  = 1'b0;
    m_req_tdata  = '0;
    m_req_tkeep  = '0;
    m_req_tstrb  = '0;
    m_req_tlast  = 1'b0;
    m_req_src    = '0;
    m_req_dst    = '0;
    m_req_tvalid = 1'b0;
    s_req_tready = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_grant_nxt = w_arb_idx;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        m_req_tdata           = w_req_data[r_grant];
        m_req_tkeep           = w_req_keep[r_grant];
        m_req_tstrb           = w_req_strb[r_grant];
        m_req_tlast           = s_req_tlast[r_grant];
        m_req_src             = w_req_src[r_grant];
        m_req_dst             = w_req_dst[r_grant];
        m_req_tvalid          = s_req_tvalid[r_grant];
        s_req_tready[r_grant] = m_req_tready;
        // Grant is released only at the end of a packet, so multi-flit packets stay whole.
        w_last_fire = s_req_tvalid[r_grant] & m_req_tready & s_req_tlast[r_grant];
        if (w_last_fire) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = (r_grant == PW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_pkt_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_last_fire && (r_grant == PW'(i))) begin
          r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Response routing: lowest-index port whose ID matches dst wins.
  always_comb begin
    w_resp_hit = 1'b0;
    w_resp_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!w_resp_hit && (m_resp_dst == PORT_IDS[8*i +: 8])) begin
        w_resp_hit = 1'b1;
        w_resp_idx = PW'(i);
      end
    end
  end

  always_comb begin
    s_resp_tvalid = '0;
    // Unroutable flits are accepted and dropped so the shared stream never stalls.
    m_resp_tready = 1'b1;
    if (w_resp_hit) begin
      s_resp_tvalid[w_resp_idx] = m_resp_tvalid;
      m_resp_tready             = s_resp_tready[w_resp_idx];
    end
  end

  // Payload fans out to every port; only tvalid qualifies the destination.
  assign s_resp_tdata = {NUM_PORTS{m_resp_tdata}};
  assign s_resp_tkeep = {NUM_PORTS{m_resp_tkeep}};
  assign s_resp_tstrb = {NUM_PORTS{m_resp_tstrb}};
  assign s_resp_tlast = {NUM_PORTS{m_resp_tlast}};
  assign s_resp_src   = {NUM_PORTS{m_resp_src}};
  assign s_resp_dst   = {NUM_PORTS{m_resp_dst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (m_resp_tvalid && !w_resp_hit) begin
      r_err <= 1'b1;
    end
  end

  assign err_unroutable = r_err;

endmodule

// File: tb/tb_lii_req_arbiter.sv
module tb_lii_req_arbiter;

  localparam int NP = 4;
  localparam int DW = 128;
  localparam int KW = DW / 8;

  // Expected m_req flit tags: {8'h00, port, packet index, flit index}.
  localparam logic [31:0] EXP_B [9] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                                        32'h0002_0000, 32'h0002_0001, 32'h0002_0002,
                                        32'h0000_0100, 32'h0000_0101, 32'h0000_0102};
  localparam logic [31:0] EXP_C [8] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                                        32'h0003_0000, 32'h0000_0100, 32'h0001_0100,
                                        32'h0002_0100, 32'h0003_0100};

  logic               clk = 1'b0;
  logic               rst;
  logic [NP*DW-1:0]   s_req_tdata;
  logic [NP*KW-1:0]   s_req_tkeep, s_req_tstrb;
  logic [NP-1:0]      s_req_tlast, s_req_tvalid, s_req_tready;
  logic [NP*8-1:0]    s_req_src, s_req_dst;
  logic [DW-1:0]      m_req_tdata;
  logic [KW-1:0]      m_req_tkeep, m_req_tstrb;
  logic               m_req_tlast, m_req_tvalid, m_req_tready;
  logic [7:0]         m_req_src, m_req_dst;
  logic [DW-1:0]      m_resp_tdata;
  logic [KW-1:0]      m_resp_tkeep, m_resp_tstrb;
  logic               m_resp_tlast, m_resp_tvalid, m_resp_tready;
  logic [7:0]         m_resp_src, m_resp_dst;
  logic [NP*DW-1:0]   s_resp_tdata;
  logic [NP*KW-1:0]   s_resp_tkeep, s_resp_tstrb;
  logic [NP-1:0]      s_resp_tlast, s_resp_tvalid, s_resp_tready;
  logic [NP*8-1:0]    s_resp_src, s_resp_dst;
  logic [NP*16-1:0]   pkt_cnt;
  logic               err_unroutable;

  lii_req_arbiter #(
    .LII_DW    (DW),
    .NUM_PORTS (NP),
    .PORT_IDS  ({8'h03, 8'h02, 8'h01, 8'h00})
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_req_tdata    (s_req_tdata),
    .s_req_tkeep    (s_req_tkeep),
    .s_req_tstrb    (s_req_tstrb),
    .s_req_tlast    (s_req_tlast),
    .s_req_src      (s_req_src),
    .s_req_dst      (s_req_dst),
    .s_req_tvalid   (s_req_tvalid),
    .s_req_tready   (s_req_tready),
    .m_req_tdata    (m_req_tdata),
    .m_req_tkeep    (m_req_tkeep),
    .m_req_tstrb    (m_req_tstrb),
    .m_req_tlast    (m_req_tlast),
    .m_req_src      (m_req_src),
    .m_req_dst      (m_req_dst),
    .m_req_tvalid   (m_req_tvalid),
    .m_req_tready   (m_req_tready),
    .m_resp_tdata   (m_resp_tdata),
    .m_resp_tkeep   (m_resp_tkeep),
    .m_resp_tstrb   (m_resp_tstrb),
    .m_resp_tlast   (m_resp_tlast),
    .m_resp_src     (m_resp_src),
    .m_resp_dst     (m_resp_dst),
    .m_resp_tvalid  (m_resp_tvalid),
    .m_resp_tready  (m_resp_tready),
    .s_resp_tdata   (s_resp_tdata),
    .s_resp_tkeep   (s_resp_tkeep),
    .s_resp_tstrb   (s_resp_tstrb),
    .s_resp_tlast   (s_resp_tlast),
    .s_resp_src     (s_resp_src),
    .s_resp_dst     (s_resp_dst),
    .s_resp_tvalid  (s_resp_tvalid),
    .s_resp_tready  (s_resp_tready),
    .pkt_cnt        (pkt_cnt),
    .err_unroutable (err_unroutable)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Requester model state: packets remaining, flits per packet, current packet/flit.
  int pkts_left [NP];
  int npf       [NP];
  int pkt_idx   [NP];
  int flit_idx  [NP];
  bit toggle_rdy = 1'b0;
  bit track_en   = 1'b0;

  logic [31:0] log_q   [$];
  int          log_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_req_tvalid[p]          = (pkts_left[p] > 0);
      s_req_tdata[p*DW +: DW]  = {96'h0, 8'h00, 8'(p), 8'(pkt_idx[p]), 8'(flit_idx[p])};
      s_req_tlast[p]           = (flit_idx[p] == npf[p] - 1);
      s_req_tkeep[p*KW +: KW]  = '1;
      s_req_tstrb[p*KW +: KW]  = '1;
      s_req_src[p*8 +: 8]      = 8'(p);
      s_req_dst[p*8 +: 8]      = 8'hA0;
    end
  endtask

  task automatic set_src(input int p, input int pkts, input int n);
    pkts_left[p] = pkts;
    npf[p]       = n;
    pkt_idx[p]   = 0;
    flit_idx[p]  = 0;
  endtask

  task automatic clear_srcs();
    for (int p = 0; p < NP; p++) set_src(p, 0, 1);
  endtask

  // One clock: sample handshakes at negedge, advance requesters just after posedge.
  task automatic step();
    logic [NP-1:0] fire;
    @(negedge clk);
    cyc++;
    fire = s_req_tvalid & s_req_tready;
    if (m_req_tvalid && m_req_tready) begin
      log_q.push_back(m_req_tdata[31:0]);
      log_cyc.push_back(cyc);
    end
    if (track_en && m_req_tvalid) begin
      check("s_req_tready3_tracks", 32'(s_req_tready[3]), 32'(m_req_tready));
      check("s_req_tready_others", 32'(s_req_tready[2:0]), 32'h0);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) begin
        flit_idx[p]++;
        if (flit_idx[p] == npf[p]) begin
          flit_idx[p] = 0;
          pkt_idx[p]++;
          pkts_left[p]--;
        end
      end
    end
    if (toggle_rdy) m_req_tready = ~m_req_tready;
    drive();
  endtask

  task automatic run_until(input int n, input int budget);
    int i = 0;
    while (log_q.size() < n && i < budget) begin
      step();
      i++;
    end
    if (log_q.size() < n) check("timeout_log_size", 32'(log_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_srcs();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    log_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    m_req_tready  = 1'b1;
    m_resp_tdata  = '0;
    m_resp_tkeep  = '0;
    m_resp_tstrb  = '0;
    m_resp_tlast  = 1'b0;
    m_resp_src    = '0;
    m_resp_dst    = '0;
    m_resp_tvalid = 1'b0;
    s_resp_tready = '0;
    clear_srcs();
    set_src(0, 1, 1);  // a valid requester while in reset must not be granted
    drive();
    #3;
    check("rst_m_req_tvalid", 32'(m_req_tvalid), 32'h0);
    check("rst_s_req_tready", 32'(s_req_tready), 32'h0);
    check("rst_pkt_cnt_lo", pkt_cnt[31:0], 32'h0);
    check("rst_pkt_cnt_hi", pkt_cnt[63:32], 32'h0);
    check("rst_err", 32'(err_unroutable), 32'h0);
    do_reset();

    // Single-flit read from port 1: one-cycle arbitration latency, then rr moves to 2.
    set_src(1, 1, 1);
    drive();
    #1;
    check("a_idle_tvalid", 32'(m_req_tvalid), 32'h0);
    check("a_idle_tdata", m_req_tdata[31:0], 32'h0);
    step();
    #1;
    check("a_tvalid", 32'(m_req_tvalid), 32'h1);
    check("a_tdata", m_req_tdata[31:0], 32'h0001_0000);
    check("a_tlast", 32'(m_req_tlast), 32'h1);
    check("a_src", 32'(m_req_src), 32'h01);
    check("a_s_req_tready", 32'(s_req_tready), 32'h2);
    step();
    #1;
    check("a_pkt_cnt1", 32'(pkt_cnt[31:16]), 32'h1);
    check("a_tvalid_after", 32'(m_req_tvalid), 32'h0);
    set_src(1, 1, 1);
    set_src(2, 1, 1);
    drive();
    run_until(3, 20);
    check("a_rr_first", log_at(1), 32'h0002_0000);
    check("a_rr_second", log_at(2), 32'h0001_0000);

    // Ports 0 and 2, 3-flit packets, continuously valid.
    do_reset();
    set_src(0, 2, 3);
    set_src(2, 2, 3);
    drive();
    run_until(12, 60);
    for (int i = 0; i < 9; i++) check($sformatf("b_order%0d", i), log_at(i), EXP_B[i]);
    if (log_cyc.size() >= 4) begin
      check("b_intra_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
      check("b_inter_gap", 32'(log_cyc[3] - log_cyc[2]), 32'd2);
    end else begin
      check("b_gap_log_size", 32'(log_cyc.size()), 32'd4);
    end

    // All four ports, eight single-flit packets.
    do_reset();
    for (int p = 0; p < NP; p++) set_src(p, 2, 1);
    drive();
    run_until(8, 40);
    for (int i = 0; i < 8; i++) check($sformatf("c_order%0d", i), log_at(i), EXP_C[i]);
    step();
    for (int p = 0; p < NP; p++) check($sformatf("c_pkt_cnt%0d", p), 32'(pkt_cnt[p*16 +: 16]), 32'd2);

    // Port 3, 4-flit packet with m_req_tready toggling.
    do_reset();
    set_src(3, 1, 4);
    drive();
    toggle_rdy = 1'b1;
    track_en   = 1'b1;
    run_until(4, 30);
    repeat (3) step();
    toggle_rdy   = 1'b0;
    track_en     = 1'b0;
    m_req_tready = 1'b1;
    check("d_flit_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("d_flit%0d", i), log_at(i), 32'h0003_0000 + 32'(i));
    check("d_pkt_cnt3", 32'(pkt_cnt[63:48]), 32'd1);

    // Response routing and unroutable drop.
    m_resp_tdata  = {96'h0, 32'hC0DE_0002};
    m_resp_dst    = 8'h02;
    m_resp_tvalid = 1'b1;
    s_resp_tready = 4'b0000;
    #1;
    check("e_s_resp_tvalid", 32'(s_resp_tvalid), 32'h4);
    check("e_m_resp_tready_0", 32'(m_resp_tready), 32'h0);
    check("e_s_resp_tdata2", s_resp_tdata[2*DW +: 32], 32'hC0DE_0002);
    s_resp_tready = 4'b1011;
    #1;
    check("e_m_resp_tready_others", 32'(m_resp_tready), 32'h0);
    s_resp_tready = 4'b0100;
    #1;
    check("e_m_resp_tready_1", 32'(m_resp_tready), 32'h1);
    @(posedge clk);
    #1;
    check("e_err_clean", 32'(err_unroutable), 32'h0);
    m_resp_dst    = 8'h55;
    s_resp_tready = 4'b0000;
    #1;
    check("e_drop_tready", 32'(m_resp_tready), 32'h1);
    check("e_drop_tvalid", 32'(s_resp_tvalid), 32'h0);
    check("e_err_before_edge", 32'(err_unroutable), 32'h0);
    @(posedge clk);
    #1;
    check("e_err_set", 32'(err_unroutable), 32'h1);
    m_resp_dst = 8'h00;
    #1;
    check("e_port0_tvalid", 32'(s_resp_tvalid), 32'h1);
    @(posedge clk);
    #1;
    check("e_err_sticky", 32'(err_unroutable), 32'h1);
    m_resp_tvalid = 1'b0;

    // Reset in the middle of a port 1 packet, with rr_ptr previously moved to 2.
    do_reset();
    set_src(1, 1, 1);
    drive();
    run_until(1, 10);
    step();
    set_src(1, 1, 4);
    drive();
    run_until(3, 20);
    check("f_pkt_cnt1_before", 32'(pkt_cnt[31:16]), 32'h1);
    rst = 1'b1;
    #1;
    check("f_rst_tvalid", 32'(m_req_tvalid), 32'h0);
    check("f_rst_tready", 32'(s_req_tready), 32'h0);
    check("f_rst_tdata", m_req_tdata[31:0], 32'h0);
    check("f_rst_pkt_cnt1", 32'(pkt_cnt[31:16]), 32'h0);
    check("f_rst_err", 32'(err_unroutable), 32'h0);
    m_resp_dst    = 8'h01;
    m_resp_tvalid = 1'b1;
    #1;
    check("f_resp_in_rst", 32'(s_resp_tvalid), 32'h2);
    m_resp_tvalid = 1'b0;
    clear_srcs();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    log_cyc.delete();
    set_src(1, 1, 1);
    set_src(2, 1, 1);
    drive();
    run_until(2, 20);
    check("f_first_after_rst", log_at(0), 32'h0001_0000);
    check("f_second_after_rst", log_at(1), 32'h0002_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
